pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: data payload width (e.g. ALU result plus memory data); SHALL be at least 1.
REQ-002 SHALL have parameter CTRL_W, default 2: control payload width (e.g. MemtoReg, RegWrite); SHALL be at least 1.
REQ-003 SHALL have parameter RD_W, default 5: destination register index width.
REQ-004 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous flush; inserts a bubble.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  stage can accept a payload.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 SHALL have port in_data  input  DATA_W  upstream data.
REQ-012 SHALL have port in_rd  input  RD_W  upstream destination index.
REQ-013 SHALL have port out_valid  output  1  downstream payload valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the payload.
REQ-015 SHALL have ports out_ctrl, out_data and out_rd  output  CTRL_W, DATA_W and RD_W  registered payload.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of backpressured cycles.

Function
REQ-017 SHALL define an input transfer as in_valid && in_ready && !flush, and an output transfer as out_valid && out_ready.
REQ-018 SHALL present an accepted payload on out_* with out_valid=1 exactly 1 cycle after its input transfer when the stage was empty.
REQ-019 SHALL hold out_* stable while out_valid && !out_ready.
REQ-020 SHALL register out_ctrl as zero whenever out_valid is 0 (bubble); out_data and out_rd keep their last values.
REQ-021 SHALL, on flush=1, clear every held entry on the next edge: out_valid=0, out_ctrl=0, and any skid entry dropped.
REQ-022 SHALL give flush priority over a simultaneous input or output transfer; the upstream payload in that cycle is discarded.
REQ-023 SHALL, on a simultaneous input and output transfer, replace the output with the new payload, giving full throughput of 1 transfer per cycle.
REQ-024 SHALL preserve payload order and never drop or duplicate a payload other than by flush.
REQ-025 SHALL increment stall_cnt on each cycle with out_valid && !out_ready, saturate at all-ones, and leave it unaffected by flush.

Reset
REQ-026 SHALL, while reset=0, force out_valid=0, out_ctrl=0, out_data=0, out_rd=0, stall_cnt=0 and the skid entry empty, independent of clk.
REQ-027 SHALL begin normal operation on the first rising edge after reset returns high; reset mid-transfer loses the payload.

Configuration
REQ-028 SHALL, with PIPE_SKID_BUF_EN defined, add one skid entry: in_ready is registered and equals !skid_full; a payload arriving while the output is stalled goes to the skid entry, then moves to the output on the next output transfer.
REQ-029 SHALL, without PIPE_SKID_BUF_EN, use no skid entry and drive in_ready combinationally as out_ready || !out_valid.
REQ-030 SHALL behave identically at the output in both builds for any sequence in which in_ready is never 0 while in_valid=1.

Structure
REQ-031 SHALL take default widths (DATA_W, CTRL_W, RD_W, CNT_W) and the bubble control constant (all zeros) from a shared package, pipe_pkg.
REQ-032 SHALL place the skid entry in sub-module pipe_skid_buf, instantiated only under PIPE_SKID_BUF_EN.

Verification
REQ-033 Pass-through: with out_ready=1, send in_data=0xDEAD_BEEF, in_ctrl=2'b11, in_rd=5'd7 -> same values with out_valid=1 one cycle later; continuous stream at 1/cycle, no gaps.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles with a valid output -> out_* stable and stall_cnt=5; skid build accepts exactly 1 more payload then in_ready=0; both payloads delivered in order.
REQ-035 Flush: assert flush together with in_valid=1 and a stalled output -> next cycle out_valid=0, out_ctrl=0, skid empty, and the flushed payload never appears.
REQ-036 Async reset: pull reset low between clk edges mid-stream -> all outputs 0 immediately; first post-reset payload appears 1 cycle after acceptance.
REQ-037 Saturation: with CNT_W=4, stall for 20 cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults for the pipeline stage register: payload widths, counter width,
// the bubble control value and the output-source selector.
package pipe_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_CTRL_W = 2;
    localparam int DEF_RD_W   = 5;
    localparam int DEF_CNT_W  = 16;

    // Every control bit of a bubble is this value, so a bubble never writes back.
    localparam logic BUBBLE_CTRL_BIT = 1'b0;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_INPUT = 2'd1,
        SRC_SKID  = 2'd2
    } out_src_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel through one pipeline stage: upstream side (in_*)
// and downstream side (out_*). The stage uses the slave modport.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RD_W   = DEF_RD_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;

    modport master (
        output in_valid, in_ctrl, in_data, in_rd, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_rd
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, in_rd, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_rd
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Single skid entry that catches a payload arriving while the stage output is stalled.
// Only exists in builds with PIPE_SKID_BUF_EN defined.
`ifdef PIPE_SKID_BUF_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              pop,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic              full,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd
);

    logic              full_q, full_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RD_W-1:0]   rd_q,   rd_d;

    // load and pop never coincide: load needs an empty entry, pop a full one.
    always_comb begin
        full_d = full_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        rd_d   = rd_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            ctrl_d = in_ctrl;
            data_d = in_data;
            rd_d   = in_rd;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
        end else begin
            full_q <= full_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            rd_q   <= rd_d;
        end
    end

    assign full     = full_q;
    assign out_ctrl = ctrl_q;
    assign out_data = data_q;
    assign out_rd   = rd_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// One valid/ready pipeline register with flush, bubble control and a saturating stall counter.
// Define PIPE_SKID_BUF_EN to add a skid entry and make in_ready a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{BUBBLE_CTRL_BIT}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [RD_W-1:0]   out_rd_q,    out_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic     out_can_take;
    logic     in_ready_int;
    logic     in_xfer;
    logic     stalled;
    out_src_e out_src;

    assign out_can_take = ~out_valid_q | bus.out_ready;
    assign stalled      = out_valid_q & ~bus.out_ready;
    assign in_xfer      = bus.in_valid & in_ready_int & ~flush;

`ifdef PIPE_SKID_BUF_EN
    logic              skid_full;
    logic              skid_load;
    logic              skid_pop;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [RD_W-1:0]   skid_rd;

    // A payload accepted while the output is stalled parks in the skid entry.
    assign skid_load    = in_xfer & ~out_can_take;
    assign skid_pop     = skid_full & out_can_take & ~flush;
    assign in_ready_int = ~skid_full;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .load     (skid_load),
        .pop      (skid_pop),
        .in_ctrl  (bus.in_ctrl),
        .in_data  (bus.in_data),
        .in_rd    (bus.in_rd),
        .full     (skid_full),
        .out_ctrl (skid_ctrl),
        .out_data (skid_data),
        .out_rd   (skid_rd)
    );
`else
    assign in_ready_int = out_can_take;
`endif

    // The skid entry is older than anything on the input, so it wins the output slot.
    always_comb begin
        out_src = SRC_NONE;
`ifdef PIPE_SKID_BUF_EN
        if (skid_full) begin
            out_src = SRC_SKID;
        end else if (in_xfer) begin
            out_src = SRC_INPUT;
        end
`else
        if (in_xfer) begin
            out_src = SRC_INPUT;
        end
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        stall_cnt_d = stalled ? sat_inc(stall_cnt_q) : stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = BUBBLE_CTRL;
        end else if (out_can_take) begin
            case (out_src)
`ifdef PIPE_SKID_BUF_EN
                SRC_SKID: begin
                    out_valid_d = 1'b1;
                    out_ctrl_d  = skid_ctrl;
                    out_data_d  = skid_data;
                    out_rd_d    = skid_rd;
                end
`endif
                SRC_INPUT: begin
                    out_valid_d = 1'b1;
                    out_ctrl_d  = bus.in_ctrl;
                    out_data_d  = bus.in_data;
                    out_rd_d    = bus.in_rd;
                end
                default: begin
                    out_valid_d = 1'b0;
                    out_ctrl_d  = BUBBLE_CTRL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_rd    = out_rd_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, hand-written corner sequences and a
// randomized run against a queue-based model; works with or without PIPE_SKID_BUF_EN.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int CW = DEF_CTRL_W;
    localparam int RW = DEF_RD_W;
    localparam int NW = DEF_CNT_W;
    localparam int STALL_MAX = (1 << NW) - 1;
`ifdef PIPE_SKID_BUF_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
    } pl_t;

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic [RW-1:0] ir;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic [RW-1:0] er;
        int            es;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic flush4;
    logic [NW-1:0] stall_cnt;
    logic [3:0]    stall_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW)) bus ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW)) bus4 ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .CNT_W(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .CNT_W(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush4),
        .bus       (bus4),
        .stall_cnt (stall_cnt4)
    );

    // ---------------- reference model: ordered queue of held payloads ----------------
    pl_t           mq[$];
    logic [DW-1:0] m_last_data;
    logic [RW-1:0] m_last_rd;
    int            m_stall;

    function automatic void model_reset();
        mq.delete();
        m_last_data = '0;
        m_last_rd   = '0;
        m_stall     = 0;
    endfunction

    function automatic bit model_in_ready();
        if (SKID) return mq.size() < 2;
        return bus.out_ready || (mq.size() == 0);
    endfunction

    function automatic void model_step();
        bit  rdy;
        pl_t p;
        rdy = model_in_ready();
        if (mq.size() > 0 && !bus.out_ready && m_stall < STALL_MAX) m_stall++;
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            if (bus.in_valid && rdy) begin
                p.ctrl = bus.in_ctrl;
                p.data = bus.in_data;
                p.rd   = bus.in_rd;
                mq.push_back(p);
            end
        end
        if (mq.size() > 0) begin
            m_last_data = mq[0].data;
            m_last_rd   = mq[0].rd;
        end
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit            ev;
        logic [CW-1:0] ec;
        ev = (mq.size() > 0);
        ec = ev ? mq[0].ctrl : '0;
        chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(ev));
        chk({tag, ".out_ctrl"},  128'(bus.out_ctrl),  128'(ec));
        chk({tag, ".out_data"},  128'(bus.out_data),  128'(m_last_data));
        chk({tag, ".out_rd"},    128'(bus.out_rd),    128'(m_last_rd));
        chk({tag, ".stall_cnt"}, 128'(stall_cnt),     128'(m_stall));
    endtask

    task automatic drive(input logic iv, input pl_t p, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_ctrl   = p.ctrl;
        bus.in_data   = p.data;
        bus.in_rd     = p.rd;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic run_cycle(input string tag);
        #1;
        chk({tag, ".in_ready"}, 128'(bus.in_ready), 128'(model_in_ready()));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic pl_t mkp(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [RW-1:0] r);
        pl_t p;
        p.ctrl = c;
        p.data = d;
        p.rd   = r;
        return p;
    endfunction

    function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                                input logic [RW-1:0] ir, input logic ordy, input logic fl,
                                input logic ev, input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                                input logic [RW-1:0] er, input int es);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ir = ir; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ec = ec; v.ed = ed; v.er = er; v.es = es;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[13];
        pl_t  p;

        reset = 1'b0;
        flush4 = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        bus4.in_valid  = 1'b0;
        bus4.in_ctrl   = '0;
        bus4.in_data   = '0;
        bus4.in_rd     = '0;
        bus4.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst.out_ctrl",  128'(bus.out_ctrl),  128'(0));
        chk("rst.out_data",  128'(bus.out_data),  128'(0));
        chk("rst.out_rd",    128'(bus.out_rd),    128'(0));
        chk("rst.stall_cnt", 128'(stall_cnt),     128'(0));
        chk("rst.in_ready",  128'(bus.in_ready),  128'(1));

        // Vector table: stream, 5-cycle stall, drain, flush into empty and stalled stage
        vt[0]  = mk(1, 2'd3, 64'hDEAD_BEEF, 5'd7, 1, 0,  1, 2'd3, 64'hDEAD_BEEF, 5'd7, 0);
        vt[1]  = mk(1, 2'd1, 64'h1111,      5'd1, 1, 0,  1, 2'd1, 64'h1111,      5'd1, 0);
        vt[2]  = mk(1, 2'd2, 64'h2222,      5'd2, 1, 0,  1, 2'd2, 64'h2222,      5'd2, 0);
        vt[3]  = mk(0, 2'd0, 64'h0,         5'd0, 0, 0,  1, 2'd2, 64'h2222,      5'd2, 1);
        vt[4]  = mk(0, 2'd0, 64'h0,         5'd0, 0, 0,  1, 2'd2, 64'h2222,      5'd2, 2);
        vt[5]  = mk(0, 2'd0, 64'h0,         5'd0, 0, 0,  1, 2'd2, 64'h2222,      5'd2, 3);
        vt[6]  = mk(0, 2'd0, 64'h0,         5'd0, 0, 0,  1, 2'd2, 64'h2222,      5'd2, 4);
        vt[7]  = mk(0, 2'd0, 64'h0,         5'd0, 0, 0,  1, 2'd2, 64'h2222,      5'd2, 5);
        vt[8]  = mk(0, 2'd0, 64'h0,         5'd0, 1, 0,  0, 2'd0, 64'h2222,      5'd2, 5);
        vt[9]  = mk(0, 2'd0, 64'h0,         5'd0, 1, 0,  0, 2'd0, 64'h2222,      5'd2, 5);
        vt[10] = mk(1, 2'd3, 64'h3333,      5'd3, 0, 1,  0, 2'd0, 64'h2222,      5'd2, 5);
        vt[11] = mk(1, 2'd1, 64'h4444,      5'd4, 0, 0,  1, 2'd1, 64'h4444,      5'd4, 5);
        vt[12] = mk(0, 2'd0, 64'h0,         5'd0, 0, 1,  0, 2'd0, 64'h4444,      5'd4, 6);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].iv, mkp(vt[i].ic, vt[i].id, vt[i].ir), vt[i].ordy, vt[i].fl);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d.out_valid", i), 128'(bus.out_valid), 128'(vt[i].ev));
            chk($sformatf("tbl%0d.out_ctrl", i),  128'(bus.out_ctrl),  128'(vt[i].ec));
            chk($sformatf("tbl%0d.out_data", i),  128'(bus.out_data),  128'(vt[i].ed));
            chk($sformatf("tbl%0d.out_rd", i),    128'(bus.out_rd),    128'(vt[i].er));
            chk($sformatf("tbl%0d.stall_cnt", i), 128'(stall_cnt),     128'(vt[i].es));
        end

        // Backpressure: second payload arrives while the first is stalled
        do_reset();
        drive(1'b1, mkp(2'd1, 64'hA, 5'd10), 1'b0, 1'b0);
        run_cycle("bp.a");
        drive(1'b1, mkp(2'd2, 64'hB, 5'd11), 1'b0, 1'b0);
        run_cycle("bp.b");
        chk("bp.hold_a", 128'(bus.out_data), 128'(64'hA));
        drive(SKID ? 1'b0 : 1'b1, mkp(2'd2, 64'hB, 5'd11), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle("bp.stall");
        chk("bp.stall_cnt", 128'(stall_cnt),    128'(5));
        chk("bp.stable",    128'(bus.out_data), 128'(64'hA));
        chk("bp.in_ready",  128'(bus.in_ready), 128'(0));
        drive(SKID ? 1'b0 : 1'b1, mkp(2'd2, 64'hB, 5'd11), 1'b1, 1'b0);
        run_cycle("bp.drain_b");
        chk("bp.order_b", 128'(bus.out_data), 128'(64'hB));
        drive(1'b0, '0, 1'b1, 1'b0);
        run_cycle("bp.empty");
        chk("bp.empty_valid", 128'(bus.out_valid), 128'(0));

        // Flush with a stalled output, a held skid entry and a new payload offered
        drive(1'b1, mkp(2'd3, 64'hC, 5'd12), 1'b0, 1'b0);
        run_cycle("fl.c");
        drive(1'b1, mkp(2'd1, 64'hD, 5'd13), 1'b0, 1'b0);
        run_cycle("fl.d");
        drive(1'b1, mkp(2'd2, 64'hE, 5'd14), 1'b0, 1'b1);
        run_cycle("fl.flush");
        chk("fl.out_valid", 128'(bus.out_valid), 128'(0));
        chk("fl.out_ctrl",  128'(bus.out_ctrl),  128'(0));
        chk("fl.in_ready",  128'(bus.in_ready),  128'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle("fl.after");
            chk("fl.no_ghost", 128'(bus.out_valid), 128'(0));
        end

        // Asynchronous reset between edges in the middle of a stream
        drive(1'b1, mkp(2'd1, 64'hF, 5'd15), 1'b1, 1'b0);
        run_cycle("ar.f");
        drive(1'b1, mkp(2'd2, 64'h10, 5'd16), 1'b1, 1'b0);
        @(posedge clk);
        model_step();
        #2 reset = 1'b0;
        #1;
        chk("ar.out_valid", 128'(bus.out_valid), 128'(0));
        chk("ar.out_ctrl",  128'(bus.out_ctrl),  128'(0));
        chk("ar.out_data",  128'(bus.out_data),  128'(0));
        chk("ar.out_rd",    128'(bus.out_rd),    128'(0));
        chk("ar.stall_cnt", 128'(stall_cnt),     128'(0));
        model_reset();
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, mkp(2'd3, 64'h1234_5678, 5'd17), 1'b1, 1'b0);
        run_cycle("ar.first");
        chk("ar.first_data", 128'(bus.out_data), 128'(64'h1234_5678));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            p.ctrl = CW'($urandom);
            p.data = {$urandom, $urandom};
            p.rd   = RW'($urandom);
            drive(($urandom_range(0, 3) != 0), p, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0));
            run_cycle("rnd");
        end
        drive(1'b0, '0, 1'b1, 1'b0);

        // Stall counter saturation on the 4-bit instance
        bus4.in_valid = 1'b1;
        bus4.in_ctrl  = 2'd3;
        bus4.in_data  = 64'h55AA;
        bus4.in_rd    = 5'd9;
        bus4.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        chk("sat.loaded", 128'(bus4.out_valid), 128'(1));
        repeat (14) @(negedge clk);
        chk("sat.cnt14", 128'(stall_cnt4), 128'(14));
        repeat (6) @(negedge clk);
        chk("sat.cnt15", 128'(stall_cnt4), 128'(15));
        chk("sat.data",  128'(bus4.out_data), 128'(64'h55AA));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
